vmul_wb_collector: RTL and testbench

//  Consumer end of the vector multiplier lanes' valid/ready output interface.
//  - Captures the lock-stepped results of all NUM_THREAD multiplier lanes together with mask and ctrl fields.
//  - Buffers them in a DEPTH-entry FIFO.
//  - Drains each entry to the vector register writeback port (wvd), the scalar writeback port (wxd), or both.
//  - Sits between the vmul lane array and the writeback arbiter.

---
 rtl/vmul_wb_collector.sv | 119 +++++++++++
 tb/tb_vmul_wb_collector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vmul_wb_collector.sv
// Writeback collector for the vector multiplier lanes: buffers lock-stepped lane
// results in a small FIFO and drains each entry to the vector and/or scalar writeback ports.
module vmul_wb_collector #(
   parameter int DEPTH = 2,
   parameter int LANES = 4,
   parameter int DW    = 32,
   parameter int RW    = 6,
   parameter int WW    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [LANES*DW-1:0] in_data_i,
   input  logic [LANES-1:0]    in_mask_i,
   input  logic [5:0]          in_alu_fn_i,
   input  logic [RW-1:0]       in_reg_idxw_i,
   input  logic [WW-1:0]       in_wid_i,
   input  logic                in_wvd_i,
   input  logic                in_wxd_i,
   output logic                out_v_valid_o,
   input  logic                out_v_ready_i,
   output logic [LANES*DW-1:0] out_v_data_o,
   output logic [LANES-1:0]    out_v_mask_o,
   output logic                out_x_valid_o,
   input  logic                out_x_ready_i,
   output logic [DW-1:0]       out_x_data_o,
   output logic [RW-1:0]       out_reg_idxw_o,
   output logic [WW-1:0]       out_wid_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic                wvd;
      logic                wxd;
      logic [WW-1:0]       wid;
      logic [RW-1:0]       reg_idx;
      logic [LANES-1:0]    mask;
      logic [LANES*DW-1:0] data;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_done_v;
   logic            r_done_x;

   entry_t          w_in_entry;
   entry_t          w_head;
   logic            w_not_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_v_fire;
   logic            w_x_fire;
   logic            w_unused_alu_fn;

   // The alu fn travels with the lane beat but nothing downstream of writeback needs it.
   assign w_unused_alu_fn = ^in_alu_fn_i;

   assign w_in_entry = '{wvd: in_wvd_i, wxd: in_wxd_i, wid: in_wid_i,
                         reg_idx: in_reg_idxw_i, mask: in_mask_i, data: in_data_i};

   assign w_not_empty = (r_count != '0);
   assign w_head      = r_mem[r_rd_ptr];

   assign in_ready_o = (r_count != CW'(DEPTH));
   assign w_push     = in_valid_i & in_ready_o;

   assign out_v_valid_o = w_not_empty & w_head.wvd & ~r_done_v;
   assign out_x_valid_o = w_not_empty & w_head.wxd & ~r_done_x;
   assign w_v_fire      = out_v_valid_o & out_v_ready_i;
   assign w_x_fire      = out_x_valid_o & out_x_ready_i;

   // An entry leaves once every port it needs has completed, including this cycle.
   assign w_pop = w_not_empty
                & (~w_head.wvd | r_done_v | w_v_fire)
                & (~w_head.wxd | r_done_x | w_x_fire);

   assign out_v_data_o   = w_not_empty ? w_head.data           : '0;
   assign out_v_mask_o   = w_not_empty ? w_head.mask           : '0;
   assign out_x_data_o   = w_not_empty ? w_head.data[DW-1:0]   : '0;
   assign out_reg_idxw_o = w_not_empty ? w_head.reg_idx        : '0;
   assign out_wid_o      = w_not_empty ? w_head.wid            : '0;

   // NOTE: payload storage is deliberately not reset; the head is gated by count, so stale
   // contents are never visible, and leaving it unreset lets it map to plain flops/RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
   end

   // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_done_v <= 1'b0;
         r_done_x <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);

         if (w_pop) begin
            r_done_v <= 1'b0;
            r_done_x <= 1'b0;
         end else begin
            if (w_v_fire) r_done_v <= 1'b1;
            if (w_x_fire) r_done_x <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vmul_wb_collector.sv
// Directed bench for vmul_wb_collector: linear stimulus, hand-computed expectations,
// immediate assertions at each comparison point.
module tb_vmul_wb_collector;

   localparam int DEPTH = 2;
   localparam int LANES = 4;
   localparam int DW    = 32;
   localparam int RW    = 6;
   localparam int WW    = 2;

   logic                clk;
   logic                rst_n;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [LANES*DW-1:0] in_data_i;
   logic [LANES-1:0]    in_mask_i;
   logic [5:0]          in_alu_fn_i;
   logic [RW-1:0]       in_reg_idxw_i;
   logic [WW-1:0]       in_wid_i;
   logic                in_wvd_i;
   logic                in_wxd_i;
   logic                out_v_valid_o;
   logic                out_v_ready_i;
   logic [LANES*DW-1:0] out_v_data_o;
   logic [LANES-1:0]    out_v_mask_o;
   logic                out_x_valid_o;
   logic                out_x_ready_i;
   logic [DW-1:0]       out_x_data_o;
   logic [RW-1:0]       out_reg_idxw_o;
   logic [WW-1:0]       out_wid_o;

   int n_cmp = 0;
   int n_err = 0;

   vmul_wb_collector #(.DEPTH(DEPTH), .LANES(LANES), .DW(DW), .RW(RW), .WW(WW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .in_mask_i(in_mask_i), .in_alu_fn_i(in_alu_fn_i), .in_reg_idxw_i(in_reg_idxw_i),
      .in_wid_i(in_wid_i), .in_wvd_i(in_wvd_i), .in_wxd_i(in_wxd_i),
      .out_v_valid_o(out_v_valid_o), .out_v_ready_i(out_v_ready_i),
      .out_v_data_o(out_v_data_o), .out_v_mask_o(out_v_mask_o),
      .out_x_valid_o(out_x_valid_o), .out_x_ready_i(out_x_ready_i),
      .out_x_data_o(out_x_data_o), .out_reg_idxw_o(out_reg_idxw_o), .out_wid_o(out_wid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic wvd, input logic wxd,
                        input logic [127:0] data, input logic [3:0] mask,
                        input logic [5:0] reg_idx, input logic [1:0] wid);
      in_valid_i    = valid;
      in_wvd_i      = wvd;
      in_wxd_i      = wxd;
      in_data_i     = data;
      in_mask_i     = mask;
      in_reg_idxw_i = reg_idx;
      in_wid_i      = wid;
      in_alu_fn_i   = 6'h15;
   endtask

   localparam logic [127:0] DATA_A = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] DATA_B = 128'h00000040_00000030_00000020_00000010;
   localparam logic [127:0] DATA_C = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
   localparam logic [127:0] DATA_D = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
   localparam logic [127:0] DATA_E = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
   localparam logic [127:0] DATA_H = 128'h00000000_00000000_00000000_0000AAAA;
   localparam logic [127:0] DATA_J = 128'h00000000_00000000_00000000_12345678;

   initial begin
      rst_n         = 1'b0;
      out_v_ready_i = 1'b0;
      out_x_ready_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 6'd0, 2'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset state
      check("rst_v_valid", out_v_valid_o, 0);
      check("rst_x_valid", out_x_valid_o, 0);
      check("rst_in_ready", in_ready_o, 1);
      check("rst_v_data", out_v_data_o, 0);
      check("rst_x_data", out_x_data_o, 0);
      check("rst_reg_wid", {out_reg_idxw_o, out_wid_o, out_v_mask_o}, 0);

      // Vector-only entry
      out_v_ready_i = 1'b1;
      drive(1'b1, 1'b1, 1'b0, DATA_A, 4'hF, 6'd5, 2'd1);
      #1;
      check("a_no_comb_path", out_v_valid_o, 0);
      step();
      in_valid_i = 1'b0;
      check("a_v_valid", out_v_valid_o, 1);
      check("a_v_data", out_v_data_o, DATA_A);
      check("a_mask", out_v_mask_o, 4'hF);
      check("a_reg", out_reg_idxw_o, 6'd5);
      check("a_wid", out_wid_o, 2'd1);
      check("a_x_valid", out_x_valid_o, 0);
      check("a_x_data", out_x_data_o, 32'h1);
      step();
      check("a_popped_v", out_v_valid_o, 0);
      check("a_popped_x", out_x_valid_o, 0);

      // Both ports, scalar held off three cycles
      out_x_ready_i = 1'b0;
      drive(1'b1, 1'b1, 1'b1, DATA_B, 4'hA, 6'd9, 2'd2);
      step();
      in_valid_i = 1'b0;
      check("b_v_valid", out_v_valid_o, 1);
      check("b_x_valid", out_x_valid_o, 1);
      check("b_x_data", out_x_data_o, 32'h10);
      step();
      check("b_v_done", out_v_valid_o, 0);
      check("b_x_held1", out_x_valid_o, 1);
      step();
      check("b_v_done2", out_v_valid_o, 0);
      check("b_x_held2", out_x_valid_o, 1);
      check("b_x_data_stable", out_x_data_o, 32'h10);
      step();
      check("b_x_held3", out_x_valid_o, 1);
      check("b_reg_stable", out_reg_idxw_o, 6'd9);
      out_x_ready_i = 1'b1;
      step();
      check("b_popped_x", out_x_valid_o, 0);
      check("b_popped_v", out_v_valid_o, 0);
      check("b_empty_ready", in_ready_o, 1);

      // Back-to-back pushes into a stalled FIFO
      out_v_ready_i = 1'b0;
      out_x_ready_i = 1'b0;
      drive(1'b1, 1'b1, 1'b0, DATA_C, 4'h1, 6'd11, 2'd0);
      step();
      check("c_ready_after1", in_ready_o, 1);
      drive(1'b1, 1'b0, 1'b1, DATA_D, 4'h2, 6'd12, 2'd1);
      step();
      check("d_ready_full", in_ready_o, 0);
      drive(1'b1, 1'b1, 1'b1, DATA_E, 4'h4, 6'd13, 2'd2);
      step();
      check("e_held_ready", in_ready_o, 0);
      check("e_head_is_c", out_v_data_o, DATA_C);
      check("e_head_c_v", out_v_valid_o, 1);
      out_v_ready_i = 1'b1;
      out_x_ready_i = 1'b1;
      step();
      check("d_head_x_valid", out_x_valid_o, 1);
      check("d_head_v_valid", out_v_valid_o, 0);
      check("d_head_x_data", out_x_data_o, 32'hD0D0D0D0);
      check("d_head_reg", out_reg_idxw_o, 6'd12);
      check("d_ready_back", in_ready_o, 1);
      step();
      in_valid_i = 1'b0;
      check("e_head_v_valid", out_v_valid_o, 1);
      check("e_head_x_valid", out_x_valid_o, 1);
      check("e_head_data", out_v_data_o, DATA_E);
      check("e_head_mask", out_v_mask_o, 4'h4);
      step();
      check("e_popped_v", out_v_valid_o, 0);
      check("e_popped_x", out_x_valid_o, 0);
      check("e_popped_data", out_v_data_o, 0);

      // Silent entry followed by a vector entry
      out_v_ready_i = 1'b0;
      drive(1'b1, 1'b0, 1'b0, DATA_A, 4'h3, 6'd20, 2'd3);
      step();
      check("f_silent_v", out_v_valid_o, 0);
      check("f_silent_x", out_x_valid_o, 0);
      drive(1'b1, 1'b1, 1'b0, DATA_B, 4'h5, 6'd21, 2'd0);
      step();
      in_valid_i = 1'b0;
      check("g_v_valid", out_v_valid_o, 1);
      check("g_reg", out_reg_idxw_o, 6'd21);
      check("g_data", out_v_data_o, DATA_B);
      check("g_ready_one_entry", in_ready_o, 1);
      out_v_ready_i = 1'b1;
      step();
      check("g_popped", out_v_valid_o, 0);

      // Asynchronous reset while full and waiting on the scalar port
      out_x_ready_i = 1'b0;
      drive(1'b1, 1'b0, 1'b1, DATA_H, 4'h1, 6'd30, 2'd1);
      step();
      step();
      in_valid_i = 1'b0;
      check("h_full", in_ready_o, 0);
      check("h_x_wait", out_x_valid_o, 1);
      check("h_x_data", out_x_data_o, 32'hAAAA);
      rst_n = 1'b0;
      #1;
      check("rst_mid_x_valid", out_x_valid_o, 0);
      check("rst_mid_v_valid", out_v_valid_o, 0);
      check("rst_mid_ready", in_ready_o, 1);
      check("rst_mid_x_data", out_x_data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_x_ready_i = 1'b1;
      step();
      check("post_rst_x_valid", out_x_valid_o, 0);
      check("post_rst_ready", in_ready_o, 1);
      drive(1'b1, 1'b0, 1'b1, DATA_J, 4'h8, 6'd31, 2'd2);
      step();
      in_valid_i = 1'b0;
      check("j_x_valid", out_x_valid_o, 1);
      check("j_x_data", out_x_data_o, 32'h12345678);
      check("j_wid", out_wid_o, 2'd2);
      step();
      check("j_popped", out_x_valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
